// File: rtl/transconv_pkg.sv
// Shared definitions for the stride-2 transposed convolution stream.
//   state_e : frame FSM states
//   KERNEL, STRIDE, PAD : kernel geometry
//   widx()  : flat index of w[ky][kx] in the packed weight vector
package transconv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    FLUSH
  } state_e;

  localparam int KERNEL = 3;
  localparam int STRIDE = 2;
  localparam int PAD    = 1;

  function automatic int widx(input int ky, input int kx);
    return KERNEL * ky + kx;
  endfunction

endpackage

// File: rtl/transconv_requant.sv
// Combinational requantiser: bias add, round-half-up arithmetic shift,
// optional ReLU and saturation to OUT_W signed bits.
//   acc     : accumulator value (signed, ACC_W)
//   bias    : signed bias (ACC_W)
//   shift   : right-shift amount, 0..ACC_W-1
//   relu_en : clamp negative results to zero
//   result  : saturated signed output (OUT_W)
module transconv_requant #(
  parameter int unsigned ACC_W = 20,
  parameter int unsigned OUT_W = 8
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [ACC_W-1:0] bias,
  input  logic        [4:0]       shift,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] result
);

  localparam int SatMaxI = 2 ** (OUT_W - 1) - 1;
  localparam int SatMinI = -SatMaxI - 1;

  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W:0]   sum_ext;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   shifted;
  logic signed [ACC_W:0]   sat_max;
  logic signed [ACC_W:0]   sat_min;
  logic signed [ACC_W:0]   clamped;

  always_comb begin
    sat_max = (ACC_W+1)'(SatMaxI);
    sat_min = (ACC_W+1)'(SatMinI);
    // Bias add wraps like the accumulator; the extra bit only absorbs the rounding term.
    sum     = acc + bias;
    sum_ext = {sum[ACC_W-1], sum};
    rnd     = '0;
    if (shift == 5'd0) begin
      shifted = sum_ext;
    end else begin
      rnd     = (ACC_W+1)'(1) << (shift - 5'd1);
      shifted = (sum_ext + rnd) >>> shift;
    end
    if (relu_en && shifted[ACC_W]) begin
      shifted = '0;
    end
    if (shifted > sat_max) begin
      clamped = sat_max;
    end else if (shifted < sat_min) begin
      clamped = sat_min;
    end else begin
      clamped = shifted;
    end
    result = clamped[OUT_W-1:0];
  end

endmodule

// File: rtl/transconv_s2_stream.sv
// Streaming 3x3 stride-2 transposed convolution (k=3, s=2, p=1, output_padding=1).
// Upsamples an H x W single-channel map to 2H x 2W with requantised output.
//   clk, rst            : clock, asynchronous active-low reset
//   start               : frame start pulse, latches config; ignored while busy
//   width, height       : input frame size
//   weights, bias       : w[ky][kx] at [(3ky+kx)*W_W +: W_W], signed bias
//   shift, relu_en      : requant rounding shift and ReLU enable
//   in_data/valid/ready : raster-order input stream
//   out_data/valid/ready: raster-order output stream
//   out_last            : last pixel of an output row
//   out_frame_last      : last pixel of the frame
//   busy, done          : frame in progress, pulse after the final handshake
module transconv_s2_stream
  import transconv_pkg::*;
#(
  parameter int unsigned IN_W       = 8,
  parameter int unsigned W_W        = 8,
  parameter int unsigned ACC_W      = 20,
  parameter int unsigned OUT_W      = 8,
  parameter int unsigned MAX_WIDTH  = 128,
  parameter int unsigned MAX_HEIGHT = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [$clog2(MAX_WIDTH+1)-1:0]  width,
  input  logic [$clog2(MAX_HEIGHT+1)-1:0] height,
  input  logic [9*W_W-1:0]              weights,
  input  logic signed [ACC_W-1:0]       bias,
  input  logic [4:0]                    shift,
  input  logic                          relu_en,
  input  logic signed [IN_W-1:0]        in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic signed [OUT_W-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          out_frame_last,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned CW    = $clog2(MAX_WIDTH + 1);
  localparam int unsigned HW    = $clog2(MAX_HEIGHT + 1);
  localparam int unsigned AW    = $clog2(2 * MAX_WIDTH);
  localparam int unsigned Depth = 2 * MAX_WIDTH;

  // Buffer role r (0: row 2i-1, 1: row 2i, 2: row 2i+1) maps to physical buffer (rot+r) mod 3.
  function automatic logic [1:0] bidx(input logic [1:0] p, input logic [1:0] r);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, r};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  state_e                  state_q;
  logic                    in_ready_q;
  logic [CW-1:0]           col_q;
  logic [HW-1:0]           row_q;
  logic [AW-1:0]           x_q;
  logic [1:0]              phase_q;
  logic [1:0]              rot_q;

  logic [CW-1:0]           width_q;
  logic [HW-1:0]           height_q;
  logic [9*W_W-1:0]        weights_q;
  logic signed [ACC_W-1:0] bias_q;
  logic [4:0]              shift_q;
  logic                    relu_q;

  logic signed [ACC_W-1:0] line_q [3][Depth];

  logic                    f_valid_q;
  logic signed [ACC_W-1:0] f_data_q;
  logic                    f_last_q;
  logic                    f_flast_q;
  logic                    out_valid_q;
  logic signed [OUT_W-1:0] out_data_q;
  logic                    out_last_q;
  logic                    out_flast_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    start_acc;
  logic                    in_acc;
  logic                    out_adv;
  logic                    f_adv;
  logic                    out_hs;
  logic                    issue;
  logic                    col_last;
  logic                    row_last;
  logic                    x_last;
  logic [AW-1:0]           last_x;
  logic [AW-1:0]           base;
  logic [AW-1:0]           acc_addr [KERNEL];
  logic signed [ACC_W-1:0] prod [KERNEL*KERNEL];
  logic [1:0]              rd_buf;
  logic signed [ACC_W-1:0] rd_data;
  logic signed [OUT_W-1:0] rq_data;

  always_comb begin
    start_acc = start && (state_q == IDLE) && !busy_q;
    in_acc    = in_valid && in_ready_q;
    out_hs    = out_valid_q && out_ready;
    out_adv   = !out_valid_q || out_ready;
    f_adv     = !f_valid_q || out_adv;
    issue     = ((state_q == DRAIN) || (state_q == FLUSH)) && f_adv;
    col_last  = (col_q == width_q - 1'b1);
    row_last  = (row_q == height_q - 1'b1);
    last_x    = AW'({width_q, 1'b0} - (CW+1)'(1));
    x_last    = (x_q == last_x);
    base      = AW'(col_q * STRIDE);
    for (int kx = 0; kx < KERNEL; kx++) begin
      acc_addr[kx] = base + AW'(kx) - AW'(PAD);
    end
    for (int k = 0; k < KERNEL * KERNEL; k++) begin
      prod[k] = ACC_W'($signed(in_data) * $signed(weights_q[k*W_W +: W_W]));
    end
    rd_buf  = bidx(rot_q, phase_q);
    rd_data = line_q[rd_buf][x_q];
  end

  // Frame FSM, counters and config latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      x_q        <= '0;
      phase_q    <= '0;
      rot_q      <= '0;
      width_q    <= '0;
      height_q   <= '0;
      weights_q  <= '0;
      bias_q     <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            width_q    <= width;
            height_q   <= height;
            weights_q  <= weights;
            bias_q     <= bias;
            shift_q    <= shift;
            relu_q     <= relu_en;
            col_q      <= '0;
            row_q      <= '0;
            x_q        <= '0;
            rot_q      <= '0;
            in_ready_q <= 1'b1;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_acc) begin
            if (col_last) begin
              col_q      <= '0;
              x_q        <= '0;
              in_ready_q <= 1'b0;
              // Row 0 has no row -1 to emit.
              phase_q    <= (row_q == '0) ? 2'd1 : 2'd0;
              state_q    <= DRAIN;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (issue) begin
            if (x_last) begin
              x_q <= '0;
              if (phase_q == 2'd0) begin
                phase_q <= 2'd1;
              end else if (row_last) begin
                phase_q <= 2'd2;
                state_q <= FLUSH;
              end else begin
                // Row 2i+1 buffer becomes row 2(i+1)-1.
                rot_q      <= bidx(rot_q, 2'd2);
                row_q      <= row_q + 1'b1;
                in_ready_q <= 1'b1;
                state_q    <= ACCUM;
              end
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (issue) begin
            if (x_last) begin
              x_q     <= '0;
              state_q <= IDLE;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line buffers: scatter-accumulate in ACCUM, read-and-clear while draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 3; b++) begin
        for (int c = 0; c < int'(Depth); c++) begin
          line_q[b][c] <= '0;
        end
      end
    end else if (in_acc) begin
      for (int ky = 0; ky < KERNEL; ky++) begin
        for (int kx = 0; kx < KERNEL; kx++) begin
          if (!((ky == 0 && row_q == '0) || (kx == 0 && col_q == '0))) begin
            line_q[bidx(rot_q, 2'(ky))][acc_addr[kx]] <=
                line_q[bidx(rot_q, 2'(ky))][acc_addr[kx]] + prod[widx(ky, kx)];
          end
        end
      end
    end else if (issue) begin
      line_q[rd_buf][x_q] <= '0;
    end
  end

  transconv_requant #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W)
  ) u_requant (
    .acc    (f_data_q),
    .bias   (bias_q),
    .shift  (shift_q),
    .relu_en(relu_q),
    .result (rq_data)
  );

  // Two-stage output pipeline: fetch register, then the output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_valid_q   <= 1'b0;
      f_data_q    <= '0;
      f_last_q    <= 1'b0;
      f_flast_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_flast_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (f_adv) begin
        f_valid_q <= issue;
        f_data_q  <= rd_data;
        f_last_q  <= x_last;
        f_flast_q <= (state_q == FLUSH) && x_last;
      end
      if (out_adv) begin
        out_valid_q <= f_valid_q;
        out_last_q  <= f_valid_q && f_last_q;
        out_flast_q <= f_valid_q && f_flast_q;
        if (f_valid_q) begin
          out_data_q <= rq_data;
        end
      end
      done_q <= out_hs && out_flast_q;
      if (start_acc) begin
        busy_q <= 1'b1;
      end else if (out_hs && out_flast_q) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign in_ready       = in_ready_q;
  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;
  assign out_frame_last = out_flast_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_transconv_s2_stream.sv
// Directed bench for transconv_s2_stream: small frames with hand-computed outputs,
// saturation/ReLU/rounding, backpressure and mid-frame reset.
module tb_transconv_s2_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  width = '0;
  logic [7:0]  height = '0;
  logic [71:0] weights = '0;
  logic [19:0] bias = '0;
  logic [4:0]  shift = '0;
  logic        relu_en = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        out_frame_last;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int in_px [16];
  int exp_px [64];
  int fac [4] = '{1, 2, 1, 1};

  always #5 clk = ~clk;

  transconv_s2_stream dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .width         (width),
    .height        (height),
    .weights       (weights),
    .bias          (bias),
    .shift         (shift),
    .relu_en       (relu_en),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .out_frame_last(out_frame_last),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] want);
    tests++;
    assert (got === want)
    else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // mode 0: w[ky][kx] = 3ky+kx+1; otherwise every weight equals mode.
  task automatic set_w(input int mode);
    for (int k = 0; k < 9; k++) weights[k*8 +: 8] = (mode == 0) ? 8'(k + 1) : 8'(mode);
  endtask

  task automatic set_s2();
    for (int k = 0; k < 4; k++) in_px[k] = 1;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) exp_px[y*4+x] = fac[y] * fac[x];
  endtask

  task automatic set_exp4(input int a, input int b, input int c, input int d);
    exp_px[0] = a; exp_px[1] = b; exp_px[2] = c; exp_px[3] = d;
  endtask

  task automatic run_frame(input string name, input int w, input int h, input bit bp,
                           input bit chk_lat);
    int n_in, n_out, in_idx, out_idx, acc_iter, first_ov, k;
    bit prev_fl, fin;
    logic signed [7:0] got_d [64];
    logic got_l [64];
    logic got_f [64];
    n_in = w * h;
    n_out = 4 * w * h;
    in_idx = 0; out_idx = 0; acc_iter = -1; first_ov = -1;
    prev_fl = 1'b0; fin = 1'b0;
    @(negedge clk);
    width = 8'(w); height = 8'(h); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble config to show the frame uses the latched copy.
    weights = {9{8'h5a}}; bias = 20'(777); shift = 5'd4; relu_en = ~relu_en;
    chk({name, " busy_rise"}, busy, 1);
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (in_idx < n_in) begin
        in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data = 8'(in_px[in_idx]);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = bp ? 1'(cyc % 2) : 1'b1;
      #1;
      chk({name, " done"}, done, prev_fl);
      if (out_idx == n_out) begin
        chk({name, " busy_fall"}, busy, 0);
        fin = 1'b1;
        break;
      end
      prev_fl = 1'b0;
      k = in_idx / w;
      // Between a row's last accepted pixel and the end of its drain, input must stall.
      if (in_idx > 0 && (in_idx % w) == 0 && (k == h || out_idx < 2*w*(2*k-1) - 2))
        chk({name, " in_ready_drain"}, in_ready, 0);
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid && out_ready) begin
        got_d[out_idx] = out_data;
        got_l[out_idx] = out_last;
        got_f[out_idx] = out_frame_last;
        if (out_frame_last) prev_fl = 1'b1;
        out_idx++;
      end
      if (in_valid && in_ready) begin
        in_idx++;
        if (in_idx == w) acc_iter = cyc;
      end
    end
    in_valid = 1'b0;
    if (!fin) chk({name, " timeout_outputs"}, out_idx, n_out);
    else begin
      if (chk_lat) chk({name, " first_latency"}, first_ov - acc_iter, 3);
      for (int i = 0; i < n_out; i++) begin
        chk($sformatf("%s data[%0d]", name, i), got_d[i], exp_px[i]);
        chk($sformatf("%s last[%0d]", name, i), got_l[i], (i % (2*w)) == 2*w-1);
        chk($sformatf("%s flast[%0d]", name, i), got_f[i], i == n_out-1);
      end
    end
  endtask

  initial begin
    int n;
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_last", out_last, 0);
    chk("rst out_frame_last", out_frame_last, 0);
    chk("rst out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b1;

    // 1x1 frame, ramp weights.
    set_w(0); bias = '0; shift = '0; relu_en = 1'b0;
    in_px[0] = 1; set_exp4(5, 6, 8, 9);
    run_frame("s1", 1, 1, 1'b0, 1'b1);

    // 2x2 all ones.
    set_w(1); bias = '0; shift = '0; relu_en = 1'b0;
    set_s2();
    run_frame("s2", 2, 2, 1'b0, 1'b0);

    // Saturation and ReLU.
    set_w(127); bias = '0; shift = '0; relu_en = 1'b0;
    in_px[0] = 127; set_exp4(127, 127, 127, 127);
    run_frame("sat_hi", 1, 1, 1'b0, 1'b0);
    set_w(127); bias = '0; shift = '0; relu_en = 1'b0;
    in_px[0] = -128; set_exp4(-128, -128, -128, -128);
    run_frame("sat_lo", 1, 1, 1'b0, 1'b0);
    set_w(127); bias = '0; shift = '0; relu_en = 1'b1;
    in_px[0] = -128; set_exp4(0, 0, 0, 0);
    run_frame("relu", 1, 1, 1'b0, 1'b0);

    // Rounding shift and negative bias.
    set_w(0); bias = '0; shift = 5'd1; relu_en = 1'b0;
    in_px[0] = 1; set_exp4(3, 3, 4, 5);
    run_frame("round", 1, 1, 1'b0, 1'b0);
    set_w(0); bias = 20'(-5); shift = '0; relu_en = 1'b0;
    in_px[0] = 1; set_exp4(0, 1, 3, 4);
    run_frame("bias", 1, 1, 1'b0, 1'b0);

    // Backpressure on both sides.
    set_w(1); bias = '0; shift = '0; relu_en = 1'b0;
    set_s2();
    run_frame("bp", 2, 2, 1'b1, 1'b0);

    // Reset during row 1 of a 4x4 frame, then a clean 2x2 frame.
    set_w(1); bias = '0; shift = '0; relu_en = 1'b0;
    @(negedge clk);
    width = 8'd4; height = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'd1; out_ready = 1'b1;
      #1;
      if (in_ready) n++;
      if (n == 6) break;
    end
    chk("mid_reached", n, 6);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid busy", busy, 0);
    chk("mid in_ready", in_ready, 0);
    chk("mid out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    set_w(1); bias = '0; shift = '0; relu_en = 1'b0;
    set_s2();
    run_frame("after_rst", 2, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/transconv_s2_stream.md
# transconv_s2_stream

Parametrised streaming 3x3 stride-2 transposed convolution for the U-Net decoder path. It upsamples one single-channel feature map of runtime size H x W to 2H x 2W, equivalent to ConvTranspose2d(k=3, s=2, p=1, output_padding=1). It sits between the decoder's channel scheduler and the skip-concat stage. Both sides use valid/ready handshakes, and the output is requantised: bias, rounding shift, optional ReLU, saturation.

## Interface
- IN_W, 8: signed input pixel width
- W_W, 8: signed weight width
- ACC_W, 20: accumulator width
- OUT_W, 8: signed output width
- MAX_WIDTH, 128: maximum input columns
- MAX_HEIGHT, 128: maximum input rows

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  frame start pulse; latches the config fields; ignored while busy
- width  in  clog2(MAX_WIDTH+1)  input columns W, 1..MAX_WIDTH
- height  in  clog2(MAX_HEIGHT+1)  input rows H, 1..MAX_HEIGHT
- weights  in  9*W_W  w[ky][kx] at bits [(3ky+kx)*W_W +: W_W]
- bias  in  ACC_W  signed bias
- shift  in  5  right-shift amount, 0..ACC_W-1
- relu_en  in  1  clamp negative results to 0
- in_data  in  IN_W  input pixel, raster order
- in_valid / in_ready  in / out  1  input handshake
- out_data  out  OUT_W  output pixel, raster order
- out_valid / out_ready  out / in  1  output handshake
- out_last  out  1  last pixel of an output row
- out_frame_last  out  1  last pixel of the frame
- busy  out  1  a frame is in progress
- done  out  1  one-cycle pulse after the final output handshake

## Operation
- Output definition: out[y][x] = sum of in[i][j]*w[ky][kx] over all i, j, ky, kx with y = 2i+ky-1 and x = 2j+kx-1.
  - Terms with y = -1 or x = -1 are dropped.
  - No term reaches y = 2H or x = 2W.
- Storage: three accumulator line buffers, each 2*MAX_WIDTH x ACC_W, assigned by rotation to output rows 2i-1, 2i and 2i+1.
- FSM states and transitions:
  - IDLE -> ACCUM on start.
  - ACCUM -> DRAIN after the W-th accepted pixel of the row.
  - DRAIN -> ACCUM when the row is not the last, otherwise DRAIN -> FLUSH.
  - FLUSH -> IDLE.
- ACCUM: in_ready = 1. Each accepted pixel j adds in*w[ky][kx] to columns 2j-1, 2j and 2j+1 of all three row buffers.
  - On row i = 0, the ky=0 writes (row -1) are suppressed.
  - The kx=0 write at j = 0 is suppressed.
  - Consecutive pixels overlap at column 2j+1; the read-modify-write must accumulate both contributions correctly.
- DRAIN: emits row 2i-1 (skipped when i = 0), then row 2i, each 2W pixels.
  - Each drained location is written to zero as it is read.
  - The row-2i+1 buffer carries over to the next row.
- FLUSH: emits row 2H-1.
- Invariant: all three buffers are zero at IDLE. Reset also zeroes them.
- Arithmetic:
  - Products are full-width signed, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; it does not saturate.
  - s = acc + bias.
  - r = s when shift = 0, otherwise (s + 2^(shift-1)) >>> shift, computed in ACC_W+1 bits.
  - If relu_en and r < 0, r = 0.
  - r is then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Config (width, height, weights, bias, shift, relu_en) is latched at start; later changes do not affect the current frame.

## Timing
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_last=0, out_frame_last=0, out_data=0. FSM in IDLE, all counters 0.
- busy rises the cycle after start is accepted and falls with done.
- in_ready is 0 in IDLE, DRAIN and FLUSH.
- The first out_valid of a drain comes 2 cycles after the edge that accepts the last input pixel of the row (one fetch cycle plus the output register).
- The output register updates when !out_valid || out_ready.
- Once valid, out_data, out_last and out_frame_last are held until the handshake completes.
- Throughput is 1 pixel/cycle with out_ready held high.
- out_last is asserted on x = 2W-1. out_frame_last is asserted on y = 2H-1, x = 2W-1.
- done pulses the cycle after the out_frame_last handshake.
- Reset mid-frame returns the block to IDLE with cleared buffers; the next start behaves as from power-up.
- With H = 1 the sequence is ACCUM, DRAIN (row 0), FLUSH (row 1).

## Structure
- transconv_pkg holds:
  - FSM state enum: IDLE, ACCUM, DRAIN, FLUSH
  - constants: KERNEL=3, STRIDE=2, PAD=1
  - weight-index helper widx(ky,kx) = 3*ky+kx
- Sub-module transconv_requant: combinational bias + rounding shift + ReLU + saturation, parameterised by ACC_W and OUT_W. It is unit-tested on its own.

## Test plan
- 1x1 input of 1, w[ky][kx] = 3ky+kx+1, bias 0, shift 0 -> outputs 5, 6, 8, 9.
  - out_last on 6 and on 9; out_frame_last and done on 9.
- 2x2 input all 1, all weights 1 -> output rows 1,2,1,1 / 2,4,2,2 / 1,2,1,1 / 1,2,1,1.
- Saturation and ReLU, 1x1 input, all weights 127:
  - input 127 -> 127 (acc 16129)
  - input -128 -> -128 (acc -16256)
  - input -128 with relu_en -> 0
- Rounding: scenario 1 with shift 1 -> 3, 3, 4, 5. With bias -5, shift 0 -> 0, 1, 3, 4.
- Backpressure: scenario 2 with out_ready toggling every cycle and random in_valid gaps.
  - Output stream is identical to scenario 2.
  - in_ready = 0 throughout DRAIN.
  - No pixel is dropped or duplicated.
- Reset mid-frame during ACCUM of row 1 of a 4x4 frame, then rerun scenario 2 -> exact scenario-2 output.
  - This checks that the buffers are cleared.
